regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001: Parameter XLEN, default 32, data width of every register.
REQ-002: Parameter NREGS, default 32, register count; power of two, at least 4; AW = clog2(NREGS).
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: we  input  1  write enable; waddr  input  AW  write index; wdata  input  XLEN  write data.
REQ-006: rs1, rs2  input  AW  read indices; rdata1, rdata2  output  XLEN  read data.
REQ-007: rs1_busy, rs2_busy  output  1  scoreboard busy bit of rs1 / rs2.
REQ-008: rsv_valid  input  1, rsv_addr  input  AW, rsv_ready  output  1  destination-reservation handshake.
REQ-009: clr_req  input  1  start bulk clear; clr_busy  output  1  clear in progress.
REQ-010: dbg_addr  input  AW, dbg_data  output  XLEN  debug read port, never bypassed.

Function
REQ-011: Index 0 SHALL read as zero on every port, ignore writes, never be busy.
REQ-012: Reads SHALL be combinational from stored state (zero added latency).
REQ-013: A write SHALL commit at the rising edge when we=1, waddr!=0, clr_busy=0; otherwise it is dropped.
REQ-014: Each register SHALL own one busy bit; rsN_busy = busy[rsN], combinational.
REQ-015: rsv_ready SHALL be 1 only when clr_busy=0 and (rsv_addr=0 or busy[rsv_addr]=0).
REQ-016: A reservation SHALL transfer when rsv_valid and rsv_ready are both 1; busy[rsv_addr] then reads 1 from the next cycle (no effect for index 0).
REQ-017: A committed write to a busy register SHALL clear its busy bit at the same edge.
REQ-018: A committed write and an accepted reservation to the same index in one cycle SHALL store the data and leave busy=1.
REQ-019: A write to a non-busy register SHALL leave its busy bit 0.
REQ-020: Clear FSM states IDLE and CLEAR; clr_req=1 in IDLE moves to CLEAR and loads counter=1.
REQ-021: In CLEAR, each cycle SHALL zero register[counter] and busy[counter], then increment; after index NREGS-1 return to IDLE (NREGS-1 cycles in CLEAR).
REQ-022: clr_busy SHALL be 1 exactly while in CLEAR; clr_req in CLEAR is ignored; writes and reservations are blocked (REQ-013, REQ-015).
REQ-023: Reads during CLEAR SHALL return current stored values (already-cleared indices read zero).

Reset
REQ-024: On rst_n=0, all registers SHALL become zero, all busy bits 0, FSM IDLE, counter 0, immediately and independent of clk.
REQ-025: Reset asserted mid-CLEAR SHALL abort the clear; after release clr_busy=0, rsv_ready=1 for any index.
REQ-026: Output reset values: rdata1/2=0, dbg_data=0, rs1/2_busy=0, clr_busy=0, rsv_ready=1.

Configuration
REQ-027: Macro REGFILE_BYPASS_EN defined: rdataN SHALL return wdata when we=1, waddr=rsN!=0, clr_busy=0 (same-cycle forwarding).
REQ-028: Macro REGFILE_BYPASS_EN undefined: rdataN SHALL return the stored (pre-write) value; busy outputs unaffected in both builds.

Verification
REQ-029: After reset, write x5=0xDEADBEEF, next cycle rs1=5 -> rdata1=0xDEADBEEF; write x0=0x1234, rs2=0 -> rdata2=0.
REQ-030: Same cycle we=1, waddr=7, wdata=0xA5A5A5A5, rs1=7 -> rdata1=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without.
REQ-031: Reserve x9 -> next cycle rs1_busy=1 (rs1=9), rsv_ready=0 for rsv_addr=9; write x9=0x55 -> busy 0 next cycle, rdata1=0x55.
REQ-032: Same cycle reserve x3 (idle) and write x3=0x77 -> x3 reads 0x77 and busy[3]=1.
REQ-033: Fill x1..x31 with index value, pulse clr_req -> clr_busy high 31 cycles, write of x4 during clear dropped, afterward all reads 0, all busy 0.
REQ-034: Assert rst_n=0 at cycle 10 of a clear -> clr_busy=0 and all registers 0 asynchronously.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: XLEN x NREGS register file with per-register busy
// (scoreboard) bits, a destination-reservation handshake, a multi-cycle
// bulk-clear FSM and a never-bypassed debug read port.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, rdata1/rdata2
// forward same-cycle write data; when undefined they return stored state.
//
// Handshake: a reservation transfers on a rising edge where rsv_valid=1 and
// rsv_ready=1; rsv_ready depends only on stored state and rsv_addr (never on
// rsv_valid), and the source may drop or change a request at any time.
//
// The clear FSM has two states and clr_busy is exactly (state == CLEAR), so
// clr_busy is the observable copy of the FSM state.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ready,
  input  logic            clr_req,
  output logic            clr_busy,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]    regs_q [NREGS];
  logic [NREGS-1:0]   busy_q, busy_d;

  logic               wr_en;
  logic               rsv_fire;
  logic               clr_act;

  // Clearing blocks the write and reservation paths; index 0 is never a target.
  assign clr_act  = (state_q == CLEAR);
  assign clr_busy = clr_act;
  assign wr_en    = we && (waddr != '0) && !clr_act;
  assign rsv_ready = !clr_act && ((rsv_addr == '0) || !busy_q[rsv_addr]);
  assign rsv_fire = rsv_valid && rsv_ready && (rsv_addr != '0);

  // Clear FSM next state and sweep counter (starts at 1, index 0 is hardwired).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy bits: sweep clears, a reservation sets (and wins over a same-index
  // write), a committed write releases.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (clr_act && (cnt_q == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else if (rsv_fire && (rsv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (waddr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register storage: writes commit when allowed, the sweep zeroes one entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (clr_act && (cnt_q == AW'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_en && (waddr == AW'(i))) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  // Combinational read ports; index 0 always reads zero and is never busy.
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : regs_q[rs1];
    rdata2 = (rs2 == '0) ? '0 : regs_q[rs2];
    if (wr_en && (waddr == rs1)) rdata1 = wdata;
    if (wr_en && (waddr == rs2)) rdata2 = wdata;
  end
`else
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : regs_q[rs1];
    rdata2 = (rs2 == '0) ? '0 : regs_q[rs2];
  end
`endif

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard (XLEN=32, NREGS=32).
// Inputs change at the falling edge; outputs are sampled 1ns later, well
// away from the rising edge that commits state.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            rs1_busy, rs2_busy;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic            clr_req;
  logic            clr_busy;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int checks;
  int failures;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Clock: 10ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and return to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; rsv_addr = '0; clr_req = 1'b0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    rsv_valid = 1'b1; rsv_addr = a;
    tick();
    rsv_valid = 1'b0;
  endtask

  // Counts nonzero registers and set busy bits across the whole file.
  task automatic scan(output int nz, output int nb);
    nz = 0; nb = 0;
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = AW'(i); rs1 = AW'(i);
      #1;
      if (dbg_data !== '0) nz++;
      if (rs1_busy !== 1'b0) nb++;
    end
  endtask

  initial begin
    int n, nz, nb;
    logic [XLEN-1:0] exp_byp;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    idle_inputs();
    rs1 = 5'd3; rs2 = 5'd4; dbg_addr = 5'd5;

    // Reset values, before any clock edge.
    #1;
    check("rst_rdata1", rdata1, 0);
    check("rst_rdata2", rdata2, 0);
    check("rst_dbg", dbg_data, 0);
    check("rst_busy1", rs1_busy, 0);
    check("rst_busy2", rs2_busy, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_rsv_ready", rsv_ready, 1);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write/read and index 0.
    write_reg(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5; dbg_addr = 5'd5; #1;
    check("x5_rdata1", rdata1, 32'hDEADBEEF);
    check("x5_dbg", dbg_data, 32'hDEADBEEF);
    write_reg(5'd0, 32'h1234);
    rs2 = 5'd0; dbg_addr = 5'd0; #1;
    check("x0_rdata2", rdata2, 0);
    check("x0_dbg", dbg_data, 0);

    // Same-cycle read of a register being written.
    write_reg(5'd7, 32'h11);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; rs1 = 5'd7; dbg_addr = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h11;
`endif
    check("x7_same_cycle", rdata1, exp_byp);
    check("x7_dbg_no_bypass", dbg_data, 32'h11);
    check("x7_busy_unaffected", rs1_busy, 0);
    tick();
    we = 1'b0; #1;
    check("x7_after", rdata1, 32'hA5A5A5A5);

    // Reservation then releasing write.
    rsv_addr = 5'd9; #1;
    check("x9_ready_pre", rsv_ready, 1);
    reserve(5'd9);
    rs1 = 5'd9; rsv_addr = 5'd9; #1;
    check("x9_busy", rs1_busy, 1);
    check("x9_ready_busy", rsv_ready, 0);
    rsv_addr = 5'd0; #1;
    check("x0_ready", rsv_ready, 1);
    write_reg(5'd9, 32'h55);
    rsv_addr = 5'd9; #1;
    check("x9_busy_cleared", rs1_busy, 0);
    check("x9_rdata", rdata1, 32'h55);
    check("x9_ready_post", rsv_ready, 1);

    // Same-cycle reservation and write to x3.
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    tick();
    idle_inputs();
    rs2 = 5'd3; #1;
    check("x3_rdata2", rdata2, 32'h77);
    check("x3_busy", rs2_busy, 1);

    // Reserving index 0 never sets busy.
    reserve(5'd0);
    rs1 = 5'd0; #1;
    check("x0_never_busy", rs1_busy, 0);

    // Fill x1..x31 with their index, reserve x12, then bulk clear.
    for (int i = 1; i < NREGS; i++) write_reg(AW'(i), XLEN'(i));
    reserve(5'd12);
    rs1 = 5'd12; rs2 = 5'd31; #1;
    check("fill_x31", rdata2, 31);
    check("x12_busy_pre", rs1_busy, 1);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        rs1 = 5'd1; #1;
        check("clr_x1_not_yet", rdata1, 1);
      end
      if (n == 5) clr_req = 1'b1;
      if (n == 6) clr_req = 1'b0;
      if (n == 10) begin
        rs1 = 5'd5; rs2 = 5'd20;
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        #1;
        check("clr_x5_cleared", rdata1, 0);
        check("clr_x20_kept", rdata2, 20);
        check("clr_rsv_blocked", rsv_ready, 0);
      end
      if (n == 11) idle_inputs();
      tick();
    end
    idle_inputs();
    check("clr_cycles", n, 31);
    check("clr_busy_done", clr_busy, 0);
    dbg_addr = 5'd4; #1;
    check("clr_x4_write_dropped", dbg_data, 0);
    scan(nz, nb);
    check("clr_nonzero_regs", nz, 0);
    check("clr_busy_bits", nb, 0);

    // Reset in the middle of a clear.
    write_reg(5'd30, 32'h30);
    write_reg(5'd2, 32'h22);
    reserve(5'd25);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("mid_clr_busy", clr_busy, 1);
    rst_n = 1'b0;
    rs1 = 5'd25; rs2 = 5'd30; dbg_addr = 5'd30;
    #1;
    check("arst_clr_busy", clr_busy, 0);
    check("arst_x30", rdata2, 0);
    check("arst_dbg", dbg_data, 0);
    check("arst_busy25", rs1_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsv_addr = 5'd25; #1;
    check("post_rst_ready", rsv_ready, 1);
    tick();
    check("post_rst_idle", clr_busy, 0);
    scan(nz, nb);
    check("post_rst_nonzero", nz, 0);
    check("post_rst_busy", nb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
